ha_token_fork_ctrl: RTL and testbench



---
 rtl/ha_pkg.sv | 17 +
 rtl/ha_token_fifo.sv | 50 +++++
 rtl/ha_token_fork_ctrl.sv | 94 +++++++++
 tb/tb_ha_token_fork_ctrl.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/ha_pkg.sv
// Shared types and helpers for the token fork controller.
// Head-status states, default data width, pointer-width helper.
package ha_pkg;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    ISSUE   = 2'd1,
    PARTIAL = 2'd2
  } fork_state_e;

  localparam int DefDataBw = 32;

  function automatic int ptrBw(input int depth);
    return (depth > 2) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/ha_token_fifo.sv
// Token buffer: storage, wrapping pointers, occupancy.
// Head data is read straight from storage at the read pointer.
module ha_token_fifo
  import ha_pkg::*;
#(
  parameter int DATA_BW = DefDataBw,
  parameter int DEPTH   = 4,
  localparam int PW     = ptrBw(DEPTH),
  localparam int OW     = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic               pop,
  input  logic [DATA_BW-1:0] wrData,
  output logic [DATA_BW-1:0] headData,
  output logic [OW-1:0]      occupancy
);

  logic [DATA_BW-1:0] mem [DEPTH];
  logic [PW-1:0]      wrPtr;
  logic [PW-1:0]      rdPtr;
  logic [OW-1:0]      occ;

  // Storage write; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (push) mem[wrPtr] <= wrData;
  end

  // Pointers and occupancy, cleared by synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      occ   <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + PW'(1);
      if (pop)  rdPtr <= rdPtr + PW'(1);
      case ({push, pop})
        2'b10:   occ <= occ + OW'(1);
        2'b01:   occ <= occ - OW'(1);
        default: occ <= occ;
      endcase
    end
  end

  assign headData  = mem[rdPtr];
  assign occupancy = occ;

endmodule

// File: rtl/ha_token_fork_ctrl.sv
// Eager fork: head token offered to every consumer,
// retired once all of them have accepted it.
module ha_token_fork_ctrl
  import ha_pkg::*;
#(
  parameter int DATA_BW = DefDataBw,
  parameter int NUM_OUT = 2,
  parameter int DEPTH   = 4,
  parameter int CNT_BW  = 16,
  localparam int OW     = $clog2(DEPTH) + 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [DATA_BW-1:0]         in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [NUM_OUT*DATA_BW-1:0] out_data,
  output logic [NUM_OUT-1:0]         out_valid,
  input  logic [NUM_OUT-1:0]         out_ready,
  output logic [OW-1:0]              occupancy,
  output logic [CNT_BW-1:0]          tok_count,
  output logic                       busy
);

  fork_state_e        state;
  fork_state_e        stateNext;
  logic [NUM_OUT-1:0] done;
  logic [NUM_OUT-1:0] doneNext;
  logic [NUM_OUT-1:0] valid;
  logic [NUM_OUT-1:0] fire;
  logic               push;
  logic               retire;
  logic [OW-1:0]      occ;
  logic [DATA_BW-1:0] head;
  logic [CNT_BW-1:0]  cnt;

  assign in_ready = occ < OW'(DEPTH);
  assign push     = in_valid && in_ready;
  assign valid    = (state != EMPTY) ? ~done : '0;
  assign fire     = valid & out_ready;
  assign retire   = (state != EMPTY) && (&(done | fire));

  ha_token_fifo #(
    .DATA_BW (DATA_BW),
    .DEPTH   (DEPTH)
  ) uFifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (retire),
    .wrData    (in_data),
    .headData  (head),
    .occupancy (occ)
  );

  // Next head status and accumulated acceptance mask.
  always_comb begin
    stateNext = state;
    doneNext  = done | fire;
    if (retire) doneNext = '0;
    unique case (state)
      EMPTY: begin
        if (push) stateNext = ISSUE;
      end
      ISSUE, PARTIAL: begin
        if (retire)
          stateNext = (occ == OW'(1) && !push) ? EMPTY : ISSUE;
        else if (|doneNext)
          stateNext = PARTIAL;
      end
      default: stateNext = EMPTY;
    endcase
  end

  // State, done mask and retired-token counter.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= EMPTY;
      done  <= '0;
      cnt   <= '0;
    end else begin
      state <= stateNext;
      done  <= doneNext;
      if (retire) cnt <= cnt + CNT_BW'(1);
    end
  end

  assign out_data  = {NUM_OUT{head}};
  assign out_valid = valid;
  assign occupancy = occ;
  assign tok_count = cnt;
  assign busy      = (occ != '0);

endmodule

// File: tb/tb_ha_token_fork_ctrl.sv
// Bench for ha_token_fork_ctrl: queue-based model checked
// every cycle, plus literal expectations per scenario.
module tb_ha_token_fork_ctrl;

  localparam int DBW = 32;
  localparam int NO  = 2;
  localparam int DP  = 4;
  localparam int CBW = 16;

  logic            clk = 0;
  logic            rst;
  logic [DBW-1:0]  in_data;
  logic            in_valid;
  logic            in_ready;
  logic [NO*DBW-1:0] out_data;
  logic [NO-1:0]   out_valid;
  logic [NO-1:0]   out_ready;
  logic [2:0]      occupancy;
  logic [CBW-1:0]  tok_count;
  logic            busy;

  int passCnt = 0;
  int totCnt  = 0;
  bit en = 0;

  logic [DBW-1:0] q[$];
  logic [NO-1:0]  mDone;
  int             mCnt;

  ha_token_fork_ctrl #(
    .DATA_BW (DBW),
    .NUM_OUT (NO),
    .DEPTH   (DP),
    .CNT_BW  (CBW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .occupancy (occupancy),
    .tok_count (tok_count),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    totCnt++;
    if (act === exp) passCnt++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Reference model: FIFO of tokens plus per-consumer accepted mask.
  always @(posedge clk) begin
    logic [NO-1:0] f;
    bit ret;
    bit psh;
    if (!rst) begin
      q.delete();
      mDone = '0;
      mCnt  = 0;
    end else begin
      f   = (q.size() != 0) ? (~mDone & out_ready) : '0;
      ret = (q.size() != 0) && ((mDone | f) == {NO{1'b1}});
      psh = in_valid && (q.size() < DP);
      if (ret) begin
        void'(q.pop_front());
        mDone = '0;
        mCnt  = (mCnt + 1) % (1 << CBW);
      end else begin
        mDone = mDone | f;
      end
      if (psh) q.push_back(in_data);
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    logic [NO-1:0] ev;
    if (en) begin
      ev = (q.size() != 0) ? ~mDone : '0;
      chk("m_in_ready", 64'(in_ready), 64'(q.size() < DP));
      chk("m_out_valid", 64'(out_valid), 64'(ev));
      chk("m_occupancy", 64'(occupancy), 64'(q.size()));
      chk("m_tok_count", 64'(tok_count), 64'(mCnt));
      chk("m_busy", 64'(busy), 64'(q.size() != 0));
      for (int i = 0; i < NO; i++)
        if (ev[i])
          chk("m_out_data", 64'(out_data[i*DBW +: DBW]), 64'(q[0]));
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst = 0; in_valid = 0; in_data = '0; out_ready = '0;
    cyc(2);
    en = 1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_occ", 64'(occupancy), 64'd0);
    chk("rst_cnt", 64'(tok_count), 64'd0);
    rst = 1;
    cyc(2);

    // single token, both consumers ready
    in_valid = 1; in_data = 32'hDEADBEEF; out_ready = 2'b11;
    cyc();
    chk("db_valid", 64'(out_valid), 64'd3);
    chk("db_data", 64'(out_data), 64'hDEADBEEF_DEADBEEF);
    in_valid = 0;
    cyc();
    chk("db_cnt", 64'(tok_count), 64'd1);
    chk("db_occ", 64'(occupancy), 64'd0);
    chk("db_valid0", 64'(out_valid), 64'd0);

    // split acceptance
    in_valid = 1; in_data = 32'h11; out_ready = 2'b01;
    cyc();
    in_valid = 0;
    chk("sp_valid", 64'(out_valid), 64'd3);
    cyc();
    chk("sp_partial", 64'(out_valid), 64'd2);
    chk("sp_cnt", 64'(tok_count), 64'd1);
    out_ready = 2'b10;
    cyc();
    chk("sp_cnt2", 64'(tok_count), 64'd2);
    chk("sp_valid0", 64'(out_valid), 64'd0);

    // back-pressure fill beyond depth
    out_ready = 2'b00;
    for (int i = 1; i <= 5; i++) begin
      in_valid = 1; in_data = DBW'(i);
      cyc();
    end
    in_valid = 0;
    chk("bp_ready", 64'(in_ready), 64'd0);
    chk("bp_occ", 64'(occupancy), 64'd4);
    out_ready = 2'b11;
    for (int k = 1; k <= 4; k++) begin
      chk("bp_order", 64'(out_data[DBW-1:0]), 64'(k));
      chk("bp_valid", 64'(out_valid), 64'd3);
      cyc();
    end
    chk("bp_empty", 64'(occupancy), 64'd0);
    chk("bp_cnt", 64'(tok_count), 64'd6);

    // streaming push+retire at occupancy 1
    in_valid = 1; in_data = 32'hA;
    cyc();
    chk("st_a", 64'(out_data[DBW-1:0]), 64'hA);
    in_data = 32'hB;
    cyc();
    chk("st_b", 64'(out_data[DBW-1:0]), 64'hB);
    chk("st_occ_b", 64'(occupancy), 64'd1);
    in_data = 32'hC;
    cyc();
    chk("st_c", 64'(out_data[DBW-1:0]), 64'hC);
    chk("st_occ_c", 64'(occupancy), 64'd1);
    in_valid = 0;
    cyc();
    chk("st_cnt", 64'(tok_count), 64'd9);
    chk("st_occ0", 64'(occupancy), 64'd0);

    // reset with a partially delivered head and three tokens
    out_ready = 2'b01;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1; in_data = 32'h21 + DBW'(i);
      cyc();
    end
    in_valid = 0; out_ready = 2'b00;
    chk("pr_occ", 64'(occupancy), 64'd3);
    chk("pr_valid", 64'(out_valid), 64'd2);
    rst = 0;
    cyc();
    chk("pr_rocc", 64'(occupancy), 64'd0);
    chk("pr_rvalid", 64'(out_valid), 64'd0);
    chk("pr_rcnt", 64'(tok_count), 64'd0);
    chk("pr_rready", 64'(in_ready), 64'd1);
    rst = 1;
    in_valid = 1; in_data = 32'hDEADBEEF; out_ready = 2'b11;
    cyc();
    chk("pr_db_valid", 64'(out_valid), 64'd3);
    chk("pr_db_data", 64'(out_data), 64'hDEADBEEF_DEADBEEF);
    in_valid = 0;
    cyc();
    chk("pr_db_cnt", 64'(tok_count), 64'd1);
    chk("pr_db_occ", 64'(occupancy), 64'd0);
    cyc(2);

    en = 0;
    $display("%0d/%0d checks passed", passCnt, totCnt);
    $finish;
  end

endmodule
